// File: rtl/rgb2ycbcr_if.sv
// Pixel bus for the RGB to YCbCr converter: the RGB input side and the YCbCr output side.
// There is no handshake. The DUT accepts a pixel on every pixel_clk edge, and i_data_en only marks active video.
interface rgb2ycbcr_if;
  logic [7:0] i_r_8b;
  logic [7:0] i_g_8b;
  logic [7:0] i_b_8b;
  logic       i_h_sync;
  logic       i_v_sync;
  logic       i_data_en;
  logic [7:0] o_y_8b;
  logic [7:0] o_cb_8b;
  logic [7:0] o_cr_8b;
  logic       o_h_sync;
  logic       o_v_sync;
  logic       o_data_en;

  modport master (
    output i_r_8b, i_g_8b, i_b_8b, i_h_sync, i_v_sync, i_data_en,
    input  o_y_8b, o_cb_8b, o_cr_8b, o_h_sync, o_v_sync, o_data_en
  );

  modport slave (
    input  i_r_8b, i_g_8b, i_b_8b, i_h_sync, i_v_sync, i_data_en,
    output o_y_8b, o_cb_8b, o_cr_8b, o_h_sync, o_v_sync, o_data_en
  );
endinterface

// File: rtl/rgb2ycbcr_pipe.sv
// BT.601 full-range RGB to YCbCr converter with a fixed 3-stage pipeline.
// The stages are products, then offset sums, then shift/clamp. Syncs ride a matching 3-deep delay line.
module rgb2ycbcr_pipe (
  input  logic        pixel_clk,
  input  logic        reset_n,
  rgb2ycbcr_if.slave  px
);

  localparam logic signed [17:0] C_YR  = 18'sd77;
  localparam logic signed [17:0] C_YG  = 18'sd150;
  localparam logic signed [17:0] C_YB  = 18'sd29;
  localparam logic signed [17:0] C_CBR = -18'sd43;
  localparam logic signed [17:0] C_CBG = -18'sd85;
  localparam logic signed [17:0] C_CBB = 18'sd128;
  localparam logic signed [17:0] C_CRR = 18'sd128;
  localparam logic signed [17:0] C_CRG = -18'sd107;
  localparam logic signed [17:0] C_CRB = -18'sd21;
  localparam logic signed [17:0] OFS_Y = 18'sd128;
  localparam logic signed [17:0] OFS_C = 18'sd32896;

  logic signed [17:0] r_s, g_s, b_s;
  logic signed [17:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
  logic signed [17:0] s_y, s_cb, s_cr;
  logic [2:0]         sync_d1, sync_d2;   // {h_sync, v_sync, data_en}

  assign r_s = $signed({10'd0, px.i_r_8b});
  assign g_s = $signed({10'd0, px.i_g_8b});
  assign b_s = $signed({10'd0, px.i_b_8b});

  // With these coefficients, Cb/Cr reach 256 for saturated primaries, so the upper clamp matters.
  function automatic logic [7:0] clamp8(input logic signed [17:0] s);
    logic signed [17:0] q;
    q = s >>> 8;
    if (q < 18'sd0)
      clamp8 = 8'd0;
    else if (q > 18'sd255)
      clamp8 = 8'hff;
    else
      clamp8 = q[7:0];
  endfunction

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      p_yr  <= '0; p_yg  <= '0; p_yb  <= '0;
      p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
      p_crr <= '0; p_crg <= '0; p_crb <= '0;
      sync_d1 <= '0;
    end else begin
      p_yr  <= r_s * C_YR;  p_yg  <= g_s * C_YG;  p_yb  <= b_s * C_YB;
      p_cbr <= r_s * C_CBR; p_cbg <= g_s * C_CBG; p_cbb <= b_s * C_CBB;
      p_crr <= r_s * C_CRR; p_crg <= g_s * C_CRG; p_crb <= b_s * C_CRB;
      sync_d1 <= {px.i_h_sync, px.i_v_sync, px.i_data_en};
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_y     <= '0;
      s_cb    <= '0;
      s_cr    <= '0;
      sync_d2 <= '0;
    end else begin
      s_y     <= p_yr + p_yg + p_yb + OFS_Y;
      s_cb    <= p_cbr + p_cbg + p_cbb + OFS_C;
      s_cr    <= p_crr + p_crg + p_crb + OFS_C;
      sync_d2 <= sync_d1;
    end
  end

  // Pixel outputs blank to zero whenever the aligned data enable is low.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      px.o_y_8b    <= '0;
      px.o_cb_8b   <= '0;
      px.o_cr_8b   <= '0;
      px.o_h_sync  <= 1'b0;
      px.o_v_sync  <= 1'b0;
      px.o_data_en <= 1'b0;
    end else begin
      px.o_y_8b    <= sync_d2[0] ? clamp8(s_y)  : 8'd0;
      px.o_cb_8b   <= sync_d2[0] ? clamp8(s_cb) : 8'd0;
      px.o_cr_8b   <= sync_d2[0] ? clamp8(s_cr) : 8'd0;
      px.o_h_sync  <= sync_d2[2];
      px.o_v_sync  <= sync_d2[1];
      px.o_data_en <= sync_d2[0];
    end
  end

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Testbench for rgb2ycbcr_pipe: random and directed pixels are checked against an arithmetic model of the BT.601 equations.
// Each output word is compared with the model value for the input applied three edges earlier.
module tb_rgb2ycbcr_pipe;

  logic pixel_clk;
  logic reset_n;
  rgb2ycbcr_if px ();

  rgb2ycbcr_pipe dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .px        (px.slave)
  );

  int pass_cnt;
  int check_cnt;
  logic [26:0] exp_q[$];
  logic [26:0] exp_now;
  logic [26:0] got;

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  assign got = {px.o_h_sync, px.o_v_sync, px.o_data_en, px.o_y_8b, px.o_cb_8b, px.o_cr_8b};

  function automatic int lim(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Expected {h, v, de, y, cb, cr}, straight from the conversion equations.
  function automatic logic [26:0] model(input logic [7:0] r, g, b, input logic h, v, de);
    int ri, gi, bi, y, cb, cr;
    logic [7:0] y8, cb8, cr8;
    ri = int'(r); gi = int'(g); bi = int'(b);
    y  = lim((77 * ri + 150 * gi + 29 * bi + 128) >>> 8);
    cb = lim((-43 * ri - 85 * gi + 128 * bi + 32896) >>> 8);
    cr = lim((128 * ri - 107 * gi - 21 * bi + 32896) >>> 8);
    y8 = de ? y[7:0] : 8'd0;
    cb8 = de ? cb[7:0] : 8'd0;
    cr8 = de ? cr[7:0] : 8'd0;
    return {h, v, de, y8, cb8, cr8};
  endfunction

  task automatic flush_model();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic step(input logic [7:0] r, g, b, input logic h, v, de);
    px.i_r_8b = r; px.i_g_8b = g; px.i_b_8b = b;
    px.i_h_sync = h; px.i_v_sync = v; px.i_data_en = de;
    exp_q.push_back(model(r, g, b, h, v, de));
    @(posedge pixel_clk);
    #1;
    exp_now = exp_q.pop_front();
  endtask

  task automatic step_rand(input int de_pct);
    step(8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
         1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(99) < de_pct));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    px.i_r_8b = 8'hff; px.i_g_8b = 8'h80; px.i_b_8b = 8'h11;
    px.i_h_sync = 1'b1; px.i_v_sync = 1'b1; px.i_data_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge pixel_clk);
      #1;
      check_cnt++;
      if (got !== 27'd0) $display("FAIL reset_hold cyc%0d: got %h expected %h", i, got, 27'd0);
      else pass_cnt++;
    end
    reset_n = 1'b1;
    flush_model();
  endtask

  task automatic test_known_colours();
    logic [23:0] rgb_t [4];
    logic [23:0] ycc_t [4];
    rgb_t[0] = 24'hffffff; ycc_t[0] = {8'd255, 8'd128, 8'd128};
    rgb_t[1] = 24'h000000; ycc_t[1] = {8'd0,   8'd128, 8'd128};
    rgb_t[2] = 24'hff0000; ycc_t[2] = {8'd77,  8'd85,  8'd255};
    rgb_t[3] = 24'h0000ff; ycc_t[3] = {8'd29,  8'd255, 8'd107};
    for (int c = 0; c < 4; c++) begin
      step(rgb_t[c][23:16], rgb_t[c][15:8], rgb_t[c][7:0], 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        if (k > 0) step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        check_cnt++;
        if (got !== exp_now) $display("FAIL colour%0d_model k%0d: got %h expected %h", c, k, got, exp_now);
        else pass_cnt++;
      end
      check_cnt++;
      if (got[23:0] !== ycc_t[c] || got[24] !== 1'b1)
        $display("FAIL colour%0d_const: got %h expected %h", c, got[23:0], ycc_t[c]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1);
    step(8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
    step(8'd255, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
    check_cnt++;
    if (got[23:0] !== 24'hff8080) $display("FAIL b2b_white: got %h expected %h", got[23:0], 24'hff8080);
    else pass_cnt++;
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_cnt++;
    if (got[23:0] !== 24'h008080) $display("FAIL b2b_black: got %h expected %h", got[23:0], 24'h008080);
    else pass_cnt++;
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check_cnt++;
    if (got[23:0] !== {8'd77, 8'd85, 8'd255}) $display("FAIL b2b_red: got %h expected %h", got[23:0], {8'd77, 8'd85, 8'd255});
    else pass_cnt++;
    step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sync_pulses();
    for (int i = 0; i < 14; i++) begin
      step(8'd200, 8'd100, 8'd50, (i == 2), (i == 5), (i == 8));
      check_cnt++;
      if (got !== exp_now) $display("FAIL sync_pulse cyc%0d: got %h expected %h", i, got, exp_now);
      else pass_cnt++;
    end
  endtask

  task automatic test_blanking();
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    step(8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
    check_cnt++;
    if (got[23:0] !== 24'd0 || got !== exp_now) $display("FAIL blanking: got %h expected %h", got, exp_now);
    else pass_cnt++;
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 300; i++) begin
      step_rand(75);
      check_cnt++;
      if (got !== exp_now) $display("FAIL rand_stream cyc%0d: got %h expected %h", i, got, exp_now);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) step_rand(100);
    #2 reset_n = 1'b0;
    #1;
    check_cnt++;
    if (got !== 27'd0) $display("FAIL mid_reset_async: got %h expected %h", got, 27'd0);
    else pass_cnt++;
    px.i_r_8b = 8'hff; px.i_g_8b = 8'hff; px.i_b_8b = 8'hff;
    px.i_h_sync = 1'b1; px.i_v_sync = 1'b1; px.i_data_en = 1'b1;
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #1;
    check_cnt++;
    if (got !== 27'd0) $display("FAIL mid_reset_hold: got %h expected %h", got, 27'd0);
    else pass_cnt++;
    reset_n = 1'b1;
    flush_model();
    for (int i = 0; i < 12; i++) begin
      step_rand(80);
      check_cnt++;
      if (got !== exp_now) $display("FAIL post_reset cyc%0d: got %h expected %h", i, got, exp_now);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt = 0;
    check_cnt = 0;
    reset_n = 1'b0;
    px.i_r_8b = '0; px.i_g_8b = '0; px.i_b_8b = '0;
    px.i_h_sync = 1'b0; px.i_v_sync = 1'b0; px.i_data_en = 1'b0;
    #3;
    test_reset();
    test_known_colours();
    test_back_to_back();
    test_sync_pulses();
    test_blanking();
    test_random_stream();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_pipe.md
RGB2YCBCR_PIPE -- requirements
Module: rgb2ycbcr_pipe

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8 bits per colour component.
REQ-002 pixel_clk  input  1  Pixel clock; all registers SHALL update on its rising edge.
REQ-003 reset_n  input  1  Reset: asynchronous, active-low.
REQ-004 i_r_8b  input  8  Red component, unsigned.
REQ-005 i_g_8b  input  8  Green component, unsigned.
REQ-006 i_b_8b  input  8  Blue component, unsigned.
REQ-007 i_h_sync  input  1  Horizontal sync accompanying the input pixel.
REQ-008 i_v_sync  input  1  Vertical sync accompanying the input pixel.
REQ-009 i_data_en  input  1  Active-video qualifier for the input pixel.
REQ-010 o_y_8b  output  8  Luma Y, unsigned.
REQ-011 o_cb_8b  output  8  Blue-difference chroma Cb, offset-binary with 128 = zero.
REQ-012 o_cr_8b  output  8  Red-difference chroma Cr, offset-binary with 128 = zero.
REQ-013 o_h_sync, o_v_sync, o_data_en  output  1 each  Input sync and enable signals, delayed to align with the pixel outputs.

Function
REQ-014 Conversion SHALL be BT.601 full-range, using 8-bit-fraction integer coefficients:
  - Y = (77R + 150G + 29B + 128) >> 8
  - Cb = (-43R - 85G + 128B + 32896) >> 8
  - Cr = (128R - 107G - 21B + 32896) >> 8
REQ-015 Intermediate sums SHALL be at least 18-bit signed, so no overflow occurs before the shift.
REQ-016 Each result SHALL be clamped to 0..255 after the shift; in particular, 256 SHALL saturate to 255.
REQ-017 The pipeline SHALL have exactly 3 register stages:
  - stage 1: nine products registered;
  - stage 2: per-channel sums with offsets registered;
  - stage 3: shift, clamp and output registered.
REQ-018 Latency SHALL be 3 pixel_clk cycles from input sample to output, for both pixel data and syncs.
REQ-019 i_h_sync, i_v_sync and i_data_en SHALL pass through a 3-stage shift register, so o_* equals i_* sampled 3 edges earlier.
REQ-020 When the delayed data enable is 0, o_y_8b, o_cb_8b and o_cr_8b SHALL output 0 (blanking).
REQ-021 Throughput SHALL be one pixel per clock, with no stalls and no handshake; a new pixel is accepted every cycle.
REQ-022 Back-to-back differing pixels SHALL each produce their own result 3 cycles later, with no cross-pixel interference.

Reset
REQ-023 While reset_n = 0, all pipeline registers and all outputs SHALL be 0.
REQ-024 On deassertion, the first valid output SHALL appear 3 cycles after the first post-reset input sample.
REQ-025 A reset asserted mid-frame SHALL immediately clear all outputs and in-flight data, including the sync delay lines.

Verification
REQ-026 Hold reset_n = 0 with nonzero inputs and syncs = 1 -> all outputs are 0 throughout.
REQ-027 de = 1, one pixel per colour -> the stated response appears exactly 3 cycles later:
  - (255,255,255) -> Y=255, Cb=128, Cr=128
  - (0,0,0) -> Y=0, Cb=128, Cr=128
  - (255,0,0) -> Y=77, Cb=85, Cr=255 (saturated)
  - (0,0,255) -> Y=29, Cb=255 (saturated), Cr=107
REQ-028 Streaming, back-to-back white, black and red on consecutive cycles -> outputs present the three expected triples on consecutive cycles starting at cycle +3.
REQ-029 Single-cycle pulses on i_h_sync, i_v_sync and i_data_en at different cycles -> each o_* pulse appears exactly 3 cycles later with the same width.
REQ-030 i_data_en = 0 with input (255,255,255) -> pixel outputs are 0 at cycle +3.
REQ-031 Assert reset_n = 0 during active streaming -> outputs clear asynchronously; after release, no stale pixel from before the reset appears.
